// File: rtl/count_timer_pkg.sv
// Shared definitions for the count_timer slice: FSM encodings, direction codes
// and the per-bit carry rule used by the chained counter slices.
package count_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // A bit passes the toggle on when it is 1 counting up or 0 counting down.
  function automatic logic slice_carry(input logic t_in, input logic q_bit, input logic inc);
    return t_in & (q_bit ~^ inc);
  endfunction

endpackage

// File: rtl/count_timer_cnt_slice.sv
// One bit of the chained up/down counter: toggles on t_in, load wins over toggle,
// and forwards the toggle to the next more significant bit.
module cnt_slice
  import count_timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t_in,
  input  logic inc,
  input  logic ld,
  input  logic ld_d,
  output logic t_out,
  output logic q
);

  logic q_r;

  // Bit storage: load has priority over toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (ld) begin
      q_r <= ld_d;
    end else if (t_in) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end

  assign q     = q_r;
  assign t_out = slice_carry(t_in, q_r, inc);

endmodule

// File: rtl/count_timer.sv
// Loadable up/down interval timer with one-cycle terminal-count pulse and
// optional auto-reload, built on a ripple chain of cnt_slice bits.
module count_timer
  import count_timer_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] rld_r;
  logic [WIDTH-1:0] rld_nxt_s;
  logic             busy_r;
  logic             tc_r;
  logic             tc_nxt_s;
  logic             ld_s;
  logic [WIDTH-1:0] ld_val_s;
  logic [WIDTH-1:0] q_s;
  logic             cnt_en_s;
  logic             at_term_s;
  logic [WIDTH:0]   t_chain_s;

  // A counting edge: running, not aborted and not overridden by a load.
  assign cnt_en_s     = (state_r == ST_RUN) & ~stop & ~load;
  assign t_chain_s[0] = cnt_en_s;

  // The carry out of the top bit is set exactly when every bit already sits at
  // the terminal value for the current direction, so it doubles as the
  // terminal compare. At terminal the FSM asserts ld, which masks the toggle.
  assign at_term_s = t_chain_s[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    cnt_slice u_slice (
      .clk   (clk),
      .rst   (rst),
      .t_in  (t_chain_s[i]),
      .inc   (dir),
      .ld    (ld_s),
      .ld_d  (ld_val_s[i]),
      .t_out (t_chain_s[i+1]),
      .q     (q_s[i])
    );
  end

  // Next-state, load control and terminal pulse decode; stop > load > start > count.
  always_comb begin
    state_nxt_s = state_r;
    rld_nxt_s   = rld_r;
    tc_nxt_s    = 1'b0;
    ld_s        = 1'b0;
    ld_val_s    = load_val;
    case (state_r)
      ST_IDLE: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (load) begin
          ld_s      = 1'b1;
          rld_nxt_s = load_val;
        end else if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (load) begin
          ld_s      = 1'b1;
          rld_nxt_s = load_val;
        end else if (at_term_s) begin
          tc_nxt_s = 1'b1;
          ld_s     = 1'b1;
          if (AUTO_RELOAD != 0) begin
            ld_val_s = rld_r;
          end else begin
            ld_val_s    = q_s;
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (load) begin
          ld_s        = 1'b1;
          rld_nxt_s   = load_val;
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          ld_s        = 1'b1;
          ld_val_s    = rld_r;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control registers; busy is registered from the next state so it equals state==RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rld_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      tc_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rld_r   <= rld_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      tc_r    <= tc_nxt_s;
    end
  end

  assign q    = q_s;
  assign busy = busy_r;
  assign tc   = tc_r;

endmodule

// File: tb/tb_count_timer.sv
// Directed bench for count_timer (WIDTH=3): one instance without and one with auto-reload.
module tb_count_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [2:0] load_val;
  logic       start;
  logic       stop;
  logic       dir;
  logic [2:0] q;
  logic       busy;
  logic       tc;
  logic [2:0] q_a;
  logic       busy_a;
  logic       tc_a;

  int n_assert = 0;
  int n_fail   = 0;

  count_timer #(.WIDTH(3), .AUTO_RELOAD(0)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .dir(dir), .q(q), .busy(busy), .tc(tc)
  );

  count_timer #(.WIDTH(3), .AUTO_RELOAD(1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .dir(dir), .q(q_a), .busy(busy_a), .tc(tc_a)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int exp_q, input int exp_busy, input int exp_tc);
    chk({tag, ".q"}, int'(q), exp_q);
    chk({tag, ".busy"}, int'(busy), exp_busy);
    chk({tag, ".tc"}, int'(tc), exp_tc);
  endtask

  task automatic do_load(input logic [2:0] v);
    load = 1'b1; load_val = v; tick(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    int exp_a_q [6];
    int exp_a_tc[6];
    exp_a_q  = '{6, 7, 5, 6, 7, 5};
    exp_a_tc = '{0, 0, 1, 0, 0, 1};

    rst = 1'b1; load = 1'b0; load_val = 3'd0; start = 1'b0; stop = 1'b0; dir = 1'b0;
    #3;
    chk3("reset", 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk3("after_reset", 0, 0, 0);

    // Count down from 5, tc six edges after start, then hold in DONE
    dir = 1'b0;
    do_load(3'd5);
    chk3("dn_load", 5, 0, 0);
    do_start();
    chk3("dn_start", 5, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk3("dn_step", 5 - i, 1, 0);
    end
    tick();
    chk3("dn_tc", 0, 0, 1);
    tick();
    chk3("dn_done_hold", 0, 0, 0);

    // DONE + start reloads the saved value
    do_start();
    chk3("done_start", 5, 1, 0);

    // Asynchronous reset mid-run at q=4
    tick();
    chk3("pre_rst", 4, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk3("async_rst", 0, 0, 0);
    #1 rst = 1'b0;
    tick();
    chk3("post_rst_idle", 0, 0, 0);

    // Auto-reload: up from 5 gives 5,6,7,5,... with tc every third cycle
    dir = 1'b1;
    do_load(3'd5);
    do_start();
    chk("ar_start.q", int'(q_a), 5);
    chk("ar_start.busy", int'(busy_a), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_seq.q", int'(q_a), exp_a_q[i]);
      chk("ar_seq.tc", int'(tc_a), exp_a_tc[i]);
      chk("ar_seq.busy", int'(busy_a), 1);
    end
    do_stop();
    chk("ar_stop.busy", int'(busy_a), 0);
    chk("ar_stop.q", int'(q_a), 5);

    // Stop mid-run holds q, restart continues from the held value
    dir = 1'b0;
    do_load(3'd6);
    do_start();
    for (int i = 5; i >= 3; i--) begin
      tick();
      chk3("stop_run", i, 1, 0);
    end
    do_stop();
    chk3("stopped", 3, 0, 0);
    tick();
    chk3("stopped_hold", 3, 0, 0);
    do_start();
    chk3("restart", 3, 1, 0);
    for (int i = 2; i >= 0; i--) begin
      tick();
      chk3("restart_run", i, 1, 0);
    end
    tick();
    chk3("restart_tc", 0, 0, 1);

    // Start with q already terminal: tc after one edge
    do_load(3'd0);
    chk3("z_load", 0, 0, 0);
    do_start();
    chk3("z_start", 0, 1, 0);
    tick();
    chk3("z_tc", 0, 0, 1);
    dir = 1'b1;
    do_load(3'd7);
    do_start();
    chk3("s_start", 7, 1, 0);
    tick();
    chk3("s_tc", 7, 0, 1);

    // stop and load together in RUN: stop wins, load dropped
    dir = 1'b0;
    do_load(3'd2);
    do_start();
    chk3("sl_start", 2, 1, 0);
    stop = 1'b1; load = 1'b1; load_val = 3'd6;
    tick();
    stop = 1'b0; load = 1'b0;
    chk3("sl_both", 2, 0, 0);

    // Direction reversal at q=2 from start 4
    do_load(3'd4);
    do_start();
    chk3("dir_start", 4, 1, 0);
    tick();
    chk3("dir_3", 3, 1, 0);
    tick();
    chk3("dir_2", 2, 1, 0);
    dir = 1'b1;
    for (int i = 3; i <= 7; i++) begin
      tick();
      chk3("dir_up", i, 1, 0);
    end
    tick();
    chk3("dir_tc", 7, 0, 1);

    // Load during RUN restarts from the new value; DONE + start uses rld=4
    do_start();
    chk3("ld_run_start", 4, 1, 0);
    tick();
    chk3("ld_run_5", 5, 1, 0);
    do_load(3'd1);
    chk3("ld_run_load", 1, 1, 0);
    tick();
    chk3("ld_run_cont", 2, 1, 0);
    do_stop();
    chk3("ld_run_stop", 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
